// File: rtl/uart_rx.sv
// UART receiver: oversampled rxd deserializer with parity/stop checking and a one-entry output register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx #(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_en,
   input  logic [1:0] parity_type,
   input  logic       nstop,
   input  logic       rxd,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       rd_en,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2);
`else
   localparam logic [TW-1:0] START_TICK = TW'(OVERSAMPLE / 2 - 1);
`endif
   localparam logic [TW-1:0] BIT_TICK = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic                   bit_val;
   logic [TW-1:0]          tick;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic [1:0]             cfg_par;
   logic                   cfg_nstop;
   logic                   par_err_q;
   logic                   ferr_q;
   logic                   tick_clr;
   logic                   shift_en;
   logic                   par_chk;
   logic                   stop_chk;
   logic                   complete;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
   // hist[1] is rxd_s at mid-1, hist[0] at mid, rxd_s itself at mid+1.
   logic [1:0] hist;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) hist <= '1;
      else        hist <= {hist[0], rxd_s};
   end

   assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
   assign bit_val = rxd_s;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      tick_clr   = 1'b0;
      shift_en   = 1'b0;
      par_chk    = 1'b0;
      stop_chk   = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            tick_clr = 1'b1;
            if (rx_en && !rxd_s) state_next = START;
         end
         START: begin
            if (tick == START_TICK) begin
               tick_clr   = 1'b1;
               state_next = bit_val ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick == BIT_TICK) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_next = cfg_par[1] ? PARITY : STOP1;
            end
         end
         PARITY: begin
            if (tick == BIT_TICK) begin
               par_chk    = 1'b1;
               state_next = STOP1;
            end
         end
         STOP1: begin
            if (tick == BIT_TICK) begin
               stop_chk = 1'b1;
               if (cfg_nstop) begin
                  state_next = STOP2;
               end else begin
                  complete   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         STOP2: begin
            if (tick == BIT_TICK) begin
               stop_chk   = 1'b1;
               complete   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rx_busy = (state != IDLE);

   // Tick wraps every OVERSAMPLE cycles once past Start, keeping samples mid-bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                tick <= '0;
      else if (tick_clr)         tick <= '0;
      else if (tick == BIT_TICK) tick <= '0;
      else                       tick <= tick + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         cfg_par   <= '0;
         cfg_nstop <= 1'b0;
         par_err_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else if (state == IDLE) begin
         bit_cnt   <= '0;
         cfg_par   <= parity_type;
         cfg_nstop <= nstop;
         par_err_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         if (shift_en) begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (par_chk)  par_err_q <= bit_val ^ (^shreg) ^ cfg_par[0];
         if (stop_chk) ferr_q    <= ferr_q | ~bit_val;
      end
   end

   // Before a completion overrun implies data_valid, so data_valid & ~rd_en covers every case.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_out     <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
         overrun      <= 1'b0;
      end else if (complete) begin
         data_out     <= shreg;
         parity_error <= par_err_q;
         frame_error  <= ferr_q | ~bit_val;
         data_valid   <= 1'b1;
         overrun      <= data_valid & ~rd_en;
      end else if (rd_en && data_valid) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver and downstream peer of uart_tx. It deserializes an asynchronous rxd line into bytes using a configurable oversampling clock, checks parity and stop bits, and holds the received byte in a one-entry output register until it is read. It sits between the external RX pin and the UART register/bus interface. Frame options (parity_type, nstop) use the same encoding as uart_tx.

Parameters:
OVERSAMPLE, 16, clock cycles per bit period; even, ≥4
SYNC_STAGES, 2, rxd synchronizer flop count; ≥2

Ports:
clock  input  1  system clock (OVERSAMPLE × baud)
reset  input  1  asynchronous, active-low reset (reset=0 resets)
rx_en  input  1  receiver enable; sampled only in Idle
parity_type  input  2  [1]=parity present, [0]=odd select; expected bit = ^data ^ parity_type[0]
nstop  input  1  0: one stop bit, 1: two stop bits
rxd  input  1  serial input, idle high
data_out  output  8  last received byte
data_valid  output  1  data_out holds an unread byte
rd_en  input  1  consume data_out; clears data_valid
parity_error  output  1  parity mismatch on the byte in data_out
frame_error  output  1  stop bit sampled 0 on the byte in data_out
overrun  output  1  sticky: byte overwritten while unread
rx_busy  output  1  state ≠ Idle

Behaviour:
- Reset (reset=0, async): synchronizer flops=1, state=Idle, data_out=0, data_valid=0, parity_error=0, frame_error=0, overrun=0, rx_busy=0, tick counter=0, bit counter=0.
- rxd passes through SYNC_STAGES flops → rxd_s. All decisions use rxd_s only.
- States: Idle, Start, Data, Parity, Stop1, Stop2.
- Idle: when rx_en=1 and rxd_s=0 → Start. Clear tick counter. Latch parity_type and nstop into frame config. Later changes to rx_en, parity_type or nstop do not affect the frame in progress.
- Start: sample at tick OVERSAMPLE/2−1 (mid-bit).
  - rxd_s=1 → false start, return to Idle, no output change.
  - rxd_s=0 → Data; tick counter restarts.
- Data/Parity/Stop1/Stop2: sample every OVERSAMPLE ticks, so each sample lands mid-bit. Let t0 be the cycle Start was entered; bit j is sampled at t0+OVERSAMPLE/2−1+(j+1)·OVERSAMPLE.
- Data: shift bits in LSB first; after 8 bits → Parity if latched parity_type[1]=1, else Stop1.
- Parity: compare with expected bit; record mismatch; → Stop1.
- Stop1: rxd_s=0 records frame error. If nstop=1 → Stop2, else complete.
- Stop2: same error check; then complete.
- Complete, taken in the cycle after the final stop sample:
  - load data_out, parity_error, frame_error together; set data_valid=1; → Idle.
  - The receiver does not wait for the end of the stop bit, so a start bit arriving immediately afterwards is accepted.
- rd_en=1 with data_valid=1: data_valid=0 and overrun=0 next cycle. data_out and the error flags hold their values. rd_en with data_valid=0 is ignored.
- Completion while data_valid=1 and rd_en=0: data_out and flags are overwritten, data_valid stays 1, overrun=1.
- Completion and rd_en in the same cycle: new byte loaded, data_valid=1, overrun=0.
- Frame errors do not stall the receiver; the byte is still delivered.
- Reset mid-frame: immediate return to Idle; partial byte discarded.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every bit, including start, is the 2-of-3 majority of rxd_s at ticks mid−1, mid, mid+1. Decision and state advance happen at mid+1, so all sample points and completion shift 1 cycle later. A single-cycle glitch at mid-bit is rejected.
- Undefined: single sample at mid, as described in Behaviour.

Test Plan:
1. Reset and sequencing, OVERSAMPLE=16, bits held 16 clocks:
   - assert reset=0 mid-frame (after 3 data bits) → data_valid=0, rx_busy=0, all flags 0, state Idle.
   - then send 0xA5 8N1 → correct byte received.
2. 8N1, 0xA5, parity_type=00, nstop=0 → data_valid=1, data_out=0xA5, no errors. Assert rd_en for 1 cycle → data_valid=0.
3. Parity and stop bits:
   - parity_type=10 (even), 0x3C, parity bit 0 → parity_error=0.
   - same byte with parity bit 1 → parity_error=1.
   - parity_type=11, 0x01, parity bit 0 → parity_error=0.
   - nstop=1 with second stop bit 0 → frame_error=1.
4. rxd low for 4 clocks then high → no data_valid, rx_busy returns to 0 by cycle 8 + SYNC_STAGES.
5. Back-to-back 0x11 then 0x22 with no rd_en → data_out=0x22, overrun=1. rd_en → overrun=0.
6. With UART_RX_MAJORITY_EN, send 0x00 with a 1-cycle high glitch at mid of bit 3 → data_out=0x00. Without the macro → data_out=0x08.
